// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   WIDTH      - default operand and HI/LO width (iteration count equals WIDTH)
//   md_op_e    - op encodings presented on muldiv_unit.op
//   md_state_e - control FSM states
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } md_state_e;

  // Ops that go through the iterative datapath (mult/multu/div/divu).
  function automatic logic is_iterative(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand magnitude latch, shared shift register for the
// shift-add multiply / restoring divide, iteration counter and sign fixup.
// Ports:
//   clk, rst          - clock, async active-high reset
//   load              - latch operands/op on this edge, clear the counter
//   step              - perform one iteration on this edge
//   op_is_div         - at load: 1 = divide, 0 = multiply
//   op_is_signed      - at load: 1 = signed operation
//   a, b              - din1 (multiplicand/dividend), din2 (multiplier/divisor)
//   last              - counter has reached W-1 (the current step is the final one)
//   res_hi, res_lo    - sign-corrected result, valid once all W steps are done
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         op_is_div,
  input  logic         op_is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  localparam int CW = $clog2(W);

  // acc layout: multiply -> {carry, partial product upper, multiplier bits}
  //             divide   -> {unused, remainder, dividend/quotient bits}
  logic [2*W:0]  acc;
  logic [W-1:0]  mag_b;
  logic [W-1:0]  dividend;
  logic          is_div;
  logic          neg_main;   // product / quotient needs negation
  logic          neg_rem;    // remainder takes the dividend's sign
  logic          div_zero;
  logic [CW-1:0] cnt;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [2*W:0]  acc_next;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic [W:0]    div_diff;
  logic          div_ge;
  logic [2*W-1:0] prod;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;

  assign a_mag = (op_is_signed && a[W-1]) ? -a : a;
  assign b_mag = (op_is_signed && b[W-1]) ? -b : b;

  // One iteration of either algorithm, selected by the latched op class.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_next  = acc;
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = (div_shift >= {1'b0, mag_b});
    if (is_div) begin
      acc_next = {1'b0, (div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ge};
    end else begin
      acc_next = {1'b0, mul_sum, acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: nonblocking (<=) for all sequential state so every register samples pre-edge values.
      acc      <= '0;
      mag_b    <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= {{(W+1){1'b0}}, a_mag};
      mag_b    <= b_mag;
      dividend <= a;
      is_div   <= op_is_div;
      neg_main <= op_is_signed && (a[W-1] ^ b[W-1]);
      neg_rem  <= op_is_signed && a[W-1];
      div_zero <= (b == '0);
      cnt      <= '0;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(W - 1));

  assign prod = acc[2*W-1:0];
  assign quo  = acc[W-1:0];
  assign rem  = acc[2*W-1:W];

  // Sign fixup; divide-by-zero bypasses it so HI returns the raw dividend.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      if (div_zero) begin
        res_hi = dividend;
        res_lo = '1;
      end else begin
        res_hi = neg_rem  ? -rem : rem;
        res_lo = neg_main ? -quo : quo;
      end
    end else begin
      {res_hi, res_lo} = neg_main ? -prod : prod;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS HI/LO multiply/divide unit with control FSM and handshake.
// Ports:
//   clk, rst   - clock, async active-high reset
//   start, op  - issue request and its op (see muldiv_pkg::md_op_e)
//   din1, din2 - rs / rt operands
//   cancel     - exception flush; aborts in-flight work, drops a same-edge start
//   hi, lo     - architectural HI/LO registers
//   busy       - iterative operation in progress
//   stall      - start & busy; issuing instruction must hold
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  md_state_e        state, state_next;
  logic             accept;
  logic             accept_iter;
  logic             dp_load;
  logic             dp_step;
  logic             write_res;
  logic             last;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // A start is only taken in IDLE and is dropped by a coincident cancel.
  assign accept      = (state == IDLE) && start && !cancel;
  assign accept_iter = accept && is_iterative(op);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept_iter) state_next = RUN;
      RUN: begin
        if (cancel)    state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state != IDLE);
    dp_load   = accept_iter;
    dp_step   = (state == RUN) && !cancel;
    write_res = (state == DONE) && !cancel;
  end

  assign stall = start && busy;

  muldiv_datapath #(.W(WIDTH)) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .load         (dp_load),
    .step         (dp_step),
    .op_is_div    ((op == MD_DIV) || (op == MD_DIVU)),
    .op_is_signed ((op == MD_MULT) || (op == MD_DIV)),
    .a            (din1),
    .b            (din2),
    .last         (last),
    .res_hi       (res_hi),
    .res_lo       (res_lo)
  );

  // HI/LO: written at the DONE edge, or directly by mthi/mtlo (never both,
  // since mthi/mtlo are only accepted in IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (write_res) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (accept && (op == MD_MTHI)) begin
      hi <= din1;
    end else if (accept && (op == MD_MTLO)) begin
      lo <= din1;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] din1;
  logic [31:0] din2;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int tests_run    = 0;
  int tests_failed = 0;

  // Bench-side model of the architectural HI/LO contents.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .din1   (din1),
    .din2   (din2),
    .cancel (cancel),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    din1  = a;
    din2  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din1  = 32'hDEAD_BEEF;
    din2  = 32'h0BAD_F00D;
  endtask

  // Count falling-edge samples with busy high, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(o, a, b);
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    check({tag, " hi held"}, hi, m_hi);
    check({tag, " lo held"}, lo, m_lo);
    wait_idle(n);
    check({tag, " cycles"}, n, 32'd33);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'b000;
    din1   = '0;
    din2   = '0;
    m_hi   = '0;
    m_lo   = '0;
    #1;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic vectors
    run_op("mult -1*2",   MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",       MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult -3*-5",  MD_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
    run_op("div -7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/7",  MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div 5/0",     MD_DIV,   32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div -7/0",    MD_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu big",    MD_DIVU,  32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);

    // start while busy is stalled and ignored
    issue(MD_MULTU, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = MD_DIVU;
    din1  = 32'd1;
    din2  = 32'd1;
    #1;
    check("stall while busy", {31'b0, stall}, 32'd1);
    @(negedge clk);
    op   = MD_MTHI;
    din1 = 32'hAAAA_AAAA;
    @(negedge clk);
    start = 1'b0;
    check("mthi ignored busy", hi, m_hi);
    wait_idle(n);
    check("stall cycles", n, 32'd28);
    check("stall res hi", hi, 32'd0);
    check("stall res lo", lo, 32'd12);
    m_hi = 32'd0;
    m_lo = 32'd12;
    repeat (3) @(negedge clk);
    check("stalled req dropped", {31'b0, busy}, 32'd0);

    // Back-to-back: request held through stall is taken right after busy falls
    start = 1'b1;
    op    = MD_MULTU;
    din1  = 32'd6;
    din2  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    op   = MD_DIVU;
    din1 = 32'd100;
    din2 = 32'd7;
    check("b2b stall", {31'b0, stall}, 32'd1);
    wait_idle(n);
    check("b2b first cycles", n, 32'd33);
    check("b2b first lo", lo, 32'd42);
    check("b2b stall low", {31'b0, stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b second busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check("b2b second cycles", n, 32'd33);
    check("b2b second hi", hi, 32'd2);
    check("b2b second lo", lo, 32'd14);
    m_hi = 32'd2;
    m_lo = 32'd14;

    // mthi / mtlo
    issue(MD_MTHI, 32'h1234_5678, 32'h0);
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi lo", lo, m_lo);
    check("mthi busy", {31'b0, busy}, 32'd0);
    m_hi = 32'h1234_5678;
    issue(MD_MTLO, 32'h9ABC_DEF0, 32'h0);
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi", hi, m_hi);
    m_lo = 32'h9ABC_DEF0;

    // Reserved ops
    issue(3'b110, 32'h5555_5555, 32'h1);
    check("rsvd110 busy", {31'b0, busy}, 32'd0);
    issue(3'b111, 32'h5555_5555, 32'h1);
    check("rsvd111 busy", {31'b0, busy}, 32'd0);
    check("rsvd hi", hi, m_hi);
    check("rsvd lo", lo, m_lo);

    // cancel mid-mult
    issue(MD_MULT, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", {31'b0, busy}, 32'd0);
    check("cancel hi", hi, m_hi);
    check("cancel lo", lo, m_lo);
    repeat (40) @(negedge clk);
    check("cancel hi later", hi, m_hi);
    check("cancel lo later", lo, m_lo);

    // cancel coincident with start drops the start
    cancel = 1'b1;
    issue(MD_MTHI, 32'hFFFF_0000, 32'h0);
    check("cancel+mthi hi", hi, m_hi);
    issue(MD_MULT, 32'd3, 32'd5);
    cancel = 1'b0;
    check("cancel+mult busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-divide
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async rst hi", hi, 32'h0);
    check("async rst lo", lo, 32'h0);
    check("async rst busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;
    run_op("post rst divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
